// File: rtl/ack_type_dispatch.sv
// Steers typed command acks into CH_NUM per-type show-ahead FIFOs with valid/ready outputs.
// Latency: an ack written at edge N is presented after edge N+1. There is no input back-pressure; full or disabled channels drop and count.
module ack_type_dispatch #(
    parameter int DATA_W = 64,
    parameter int TYPE_W = 2,
    parameter int CH_NUM = 4,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [TYPE_W+DATA_W-1:0]   iv_command_ack,
    input  logic                       i_command_ack_wr,
    input  logic [CH_NUM-1:0]          iv_ch_enable,
    input  logic                       i_cnt_clr,
    output logic [CH_NUM*DATA_W-1:0]   ov_rd_command_ack,
    output logic [CH_NUM-1:0]          o_rd_command_ack_wr,
    input  logic [CH_NUM-1:0]          i_rd_command_ack_rdy,
    output logic [CH_NUM*CNT_W-1:0]    ov_drop_cnt,
    output logic [CNT_W-1:0]           ov_unknown_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [TYPE_W:0]  LP_CH_NUM = (TYPE_W+1)'(CH_NUM);
    localparam logic [PTR_W:0]   LP_DEPTH  = (PTR_W+1)'(DEPTH);

    logic [TYPE_W-1:0] w_type;
    logic [DATA_W-1:0] w_payload;
    logic              w_type_known;
    logic              w_unknown;
    logic [CNT_W-1:0]  r_unknown_cnt;

    assign w_type       = iv_command_ack[TYPE_W+DATA_W-1:DATA_W];
    assign w_payload    = iv_command_ack[DATA_W-1:0];
    assign w_type_known = ({1'b0, w_type} < LP_CH_NUM);
    assign w_unknown    = i_command_ack_wr && !w_type_known;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_cnt_clr) begin
            r_unknown_cnt <= '0;
        end else if (w_unknown && (r_unknown_cnt != '1)) begin
            r_unknown_cnt <= r_unknown_cnt + CNT_W'(1);
        end
    end

    assign ov_unknown_cnt = r_unknown_cnt;

    for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
        logic [DATA_W-1:0] r_mem [DEPTH];
        logic [PTR_W-1:0]  r_wr_ptr;
        logic [PTR_W-1:0]  r_rd_ptr;
        logic [PTR_W:0]    r_count;
        logic              r_fresh;
        logic [CNT_W-1:0]  r_drop;
        logic              w_sel;
        logic              w_full;
        logic              w_vld;
        logic              w_pop;
        logic              w_push;
        logic              w_drop;

        assign w_sel  = i_command_ack_wr && (w_type == TYPE_W'(k));
        assign w_full = (r_count == LP_DEPTH);
        // A word landing in an empty FIFO is held back one cycle, giving the registered-output latency.
        assign w_vld  = (r_count != '0) && !r_fresh;
        assign w_pop  = w_vld && i_rd_command_ack_rdy[k];
        assign w_push = w_sel && iv_ch_enable[k] && (!w_full || w_pop);
        assign w_drop = w_sel && !w_push;

        always_ff @(posedge i_clk) begin
            if (w_push && !i_rst) begin
                r_mem[r_wr_ptr] <= w_payload;
            end
        end

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
                r_fresh  <= 1'b0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                    2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                    default: r_count <= r_count;
                endcase
                r_fresh <= w_push && (r_count == '0);
            end
        end

        always_ff @(posedge i_clk) begin
            if (i_rst || i_cnt_clr) begin
                r_drop <= '0;
            end else if (w_drop && (r_drop != '1)) begin
                r_drop <= r_drop + CNT_W'(1);
            end
        end

        assign o_rd_command_ack_wr[k]              = w_vld;
        assign ov_rd_command_ack[k*DATA_W +: DATA_W] = w_vld ? r_mem[r_rd_ptr] : '0;
        assign ov_drop_cnt[k*CNT_W +: CNT_W]         = r_drop;
    end

endmodule

// File: tb/tb_ack_type_dispatch.sv
// Directed vector table for the default 4-channel build, plus a 3-channel / 4-bit counter
// instance for unknown-type counting, counter saturation and clear priority.
module tb_ack_type_dispatch;

    logic         clk = 1'b0;
    always #5 clk = ~clk;

    // Default build
    logic         rst;
    logic [65:0]  ack;
    logic         ack_wr;
    logic [3:0]   en;
    logic         clr;
    logic [255:0] rd_dat;
    logic [3:0]   rd_vld;
    logic [3:0]   rdy;
    logic [63:0]  drop;
    logic [15:0]  unk;

    ack_type_dispatch u_dut (
        .i_clk                (clk),
        .i_rst                (rst),
        .iv_command_ack       (ack),
        .i_command_ack_wr     (ack_wr),
        .iv_ch_enable         (en),
        .i_cnt_clr            (clr),
        .ov_rd_command_ack    (rd_dat),
        .o_rd_command_ack_wr  (rd_vld),
        .i_rd_command_ack_rdy (rdy),
        .ov_drop_cnt          (drop),
        .ov_unknown_cnt       (unk)
    );

    // Three-channel build with narrow counters
    logic         rst3;
    logic [65:0]  ack3;
    logic         ack_wr3;
    logic [2:0]   en3;
    logic         clr3;
    logic [191:0] rd_dat3;
    logic [2:0]   rd_vld3;
    logic [2:0]   rdy3;
    logic [11:0]  drop3;
    logic [3:0]   unk3;

    ack_type_dispatch #(.CH_NUM(3), .CNT_W(4)) u_dut3 (
        .i_clk                (clk),
        .i_rst                (rst3),
        .iv_command_ack       (ack3),
        .i_command_ack_wr     (ack_wr3),
        .iv_ch_enable         (en3),
        .i_cnt_clr            (clr3),
        .ov_rd_command_ack    (rd_dat3),
        .o_rd_command_ack_wr  (rd_vld3),
        .i_rd_command_ack_rdy (rdy3),
        .ov_drop_cnt          (drop3),
        .ov_unknown_cnt       (unk3)
    );

    typedef struct {
        logic        rst;
        logic        wr;
        logic [1:0]  typ;
        logic [63:0] pay;
        logic [3:0]  en;
        logic [3:0]  rdy;
        logic [3:0]  exp_vld;
        int          exp_ch;
        logic [63:0] exp_pay;
        int          drop_ch;
        logic [15:0] exp_drop;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t mk(logic r, logic w, logic [1:0] t, logic [63:0] p, logic [3:0] e,
                                logic [3:0] rd, logic [3:0] ev, int ec, logic [63:0] ep,
                                int dc, logic [15:0] ed);
        vec_t v;
        v.rst = r; v.wr = w; v.typ = t; v.pay = p; v.en = e; v.rdy = rd;
        v.exp_vld = ev; v.exp_ch = ec; v.exp_pay = ep; v.drop_ch = dc; v.exp_drop = ed;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [255:0] exp_bus;
        vec_t v;

        rst = 1'b1; ack = '0; ack_wr = 1'b0; en = 4'b1111; clr = 1'b0; rdy = 4'b1111;
        rst3 = 1'b1; ack3 = '0; ack_wr3 = 1'b0; en3 = 3'b101; clr3 = 1'b0; rdy3 = 3'b111;
        tick();
        tick();
        chk("reset vld", 256'(rd_vld), 256'(0));
        chk("reset dat", rd_dat, 256'(0));
        chk("reset drop", 256'(drop), 256'(0));
        chk("reset unk", 256'(unk), 256'(0));
        rst = 1'b0;
        rst3 = 1'b0;

        // single type-3 ack, all consumers ready
        tbl.push_back(mk(0, 1, 3, 64'h0123_4567_89AB_CDEF, 4'hF, 4'hF, 4'b0000, 3, 64'h0, 3, 0));
        tbl.push_back(mk(0, 0, 0, 64'h0, 4'hF, 4'hF, 4'b1000, 3, 64'h0123_4567_89AB_CDEF, 3, 0));
        tbl.push_back(mk(0, 0, 0, 64'h0, 4'hF, 4'hF, 4'b0000, 3, 64'h0, 3, 0));
        // ch1 stalled, six writes into a four-entry FIFO
        tbl.push_back(mk(0, 1, 1, 64'd1, 4'hF, 4'b1101, 4'b0000, 1, 64'd0, 1, 0));
        tbl.push_back(mk(0, 1, 1, 64'd2, 4'hF, 4'b1101, 4'b0010, 1, 64'd1, 1, 0));
        tbl.push_back(mk(0, 1, 1, 64'd3, 4'hF, 4'b1101, 4'b0010, 1, 64'd1, 1, 0));
        tbl.push_back(mk(0, 1, 1, 64'd4, 4'hF, 4'b1101, 4'b0010, 1, 64'd1, 1, 0));
        tbl.push_back(mk(0, 1, 1, 64'd5, 4'hF, 4'b1101, 4'b0010, 1, 64'd1, 1, 1));
        tbl.push_back(mk(0, 1, 1, 64'd6, 4'hF, 4'b1101, 4'b0010, 1, 64'd1, 1, 2));
        tbl.push_back(mk(0, 0, 0, 64'd0, 4'hF, 4'hF,    4'b0010, 1, 64'd2, 1, 2));
        tbl.push_back(mk(0, 0, 0, 64'd0, 4'hF, 4'hF,    4'b0010, 1, 64'd3, 1, 2));
        tbl.push_back(mk(0, 0, 0, 64'd0, 4'hF, 4'hF,    4'b0010, 1, 64'd4, 1, 2));
        tbl.push_back(mk(0, 0, 0, 64'd0, 4'hF, 4'hF,    4'b0000, 1, 64'd0, 1, 2));
        // fill ch0, then push into the full FIFO alongside a pop
        tbl.push_back(mk(0, 1, 0, 64'hA1, 4'hF, 4'b1110, 4'b0000, 0, 64'h0,  0, 0));
        tbl.push_back(mk(0, 1, 0, 64'hA2, 4'hF, 4'b1110, 4'b0001, 0, 64'hA1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 64'hA3, 4'hF, 4'b1110, 4'b0001, 0, 64'hA1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 64'hA4, 4'hF, 4'b1110, 4'b0001, 0, 64'hA1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 64'h05, 4'hF, 4'hF,    4'b0001, 0, 64'hA2, 0, 0));
        tbl.push_back(mk(0, 0, 0, 64'h0,  4'hF, 4'hF,    4'b0001, 0, 64'hA3, 0, 0));
        tbl.push_back(mk(0, 0, 0, 64'h0,  4'hF, 4'hF,    4'b0001, 0, 64'hA4, 0, 0));
        tbl.push_back(mk(0, 0, 0, 64'h0,  4'hF, 4'hF,    4'b0001, 0, 64'h05, 0, 0));
        tbl.push_back(mk(0, 0, 0, 64'h0,  4'hF, 4'hF,    4'b0000, 0, 64'h0,  0, 0));
        // ch2 disabled
        tbl.push_back(mk(0, 1, 2, 64'hC1, 4'b1011, 4'hF, 4'b0000, 2, 64'h0, 2, 1));
        tbl.push_back(mk(0, 1, 2, 64'hC2, 4'b1011, 4'hF, 4'b0000, 2, 64'h0, 2, 2));
        tbl.push_back(mk(0, 1, 2, 64'hC3, 4'b1011, 4'hF, 4'b0000, 2, 64'h0, 2, 3));
        tbl.push_back(mk(0, 0, 0, 64'h0,  4'b1011, 4'hF, 4'b0000, 2, 64'h0, 2, 3));
        // queue three on ch0, then reset with a write present
        tbl.push_back(mk(0, 1, 0, 64'hB1, 4'hF, 4'b1110, 4'b0000, 0, 64'h0,  2, 3));
        tbl.push_back(mk(0, 1, 0, 64'hB2, 4'hF, 4'b1110, 4'b0001, 0, 64'hB1, 2, 3));
        tbl.push_back(mk(0, 1, 0, 64'hB3, 4'hF, 4'b1110, 4'b0001, 0, 64'hB1, 2, 3));
        tbl.push_back(mk(1, 1, 0, 64'hB4, 4'hF, 4'b1110, 4'b0000, 0, 64'h0,  2, 0));
        tbl.push_back(mk(0, 0, 0, 64'h0,  4'hF, 4'hF,    4'b0000, 0, 64'h0,  1, 0));
        tbl.push_back(mk(0, 0, 0, 64'h0,  4'hF, 4'hF,    4'b0000, 0, 64'h0,  0, 0));
        tbl.push_back(mk(0, 0, 0, 64'h0,  4'hF, 4'hF,    4'b0000, 0, 64'h0,  3, 0));

        foreach (tbl[i]) begin
            v = tbl[i];
            rst = v.rst; ack_wr = v.wr; ack = {v.typ, v.pay}; en = v.en; rdy = v.rdy;
            tick();
            exp_bus = '0;
            if (v.exp_vld != 4'b0000) exp_bus[v.exp_ch*64 +: 64] = v.exp_pay;
            chk($sformatf("v%0d vld", i), 256'(rd_vld), 256'(v.exp_vld));
            chk($sformatf("v%0d dat", i), rd_dat, exp_bus);
            chk($sformatf("v%0d drop%0d", i, v.drop_ch), 256'(drop[v.drop_ch*16 +: 16]),
                256'(v.exp_drop));
            chk($sformatf("v%0d unk", i), 256'(unk), 256'(0));
            if (v.rst) chk($sformatf("v%0d drop all", i), 256'(drop), 256'(0));
        end
        rst = 1'b0; ack_wr = 1'b0;

        // Three-channel instance: ch1 disabled, drops drive the 4-bit counter to saturation
        ack3 = {2'd1, 64'h11};
        ack_wr3 = 1'b1;
        for (int n = 0; n < 14; n++) tick();
        chk("d3 drop1 preload", 256'(drop3[4 +: 4]), 256'(4'hE));
        for (int n = 0; n < 3; n++) begin
            tick();
            chk($sformatf("d3 drop1 sat%0d", n), 256'(drop3[4 +: 4]), 256'(4'hF));
        end
        clr3 = 1'b1;
        tick();
        chk("d3 clr with drop", 256'(drop3), 256'(0));
        clr3 = 1'b0;
        ack3 = {2'd3, 64'h33};
        tick();
        chk("d3 unknown", 256'(unk3), 256'(1));
        ack_wr3 = 1'b0;
        tick();
        chk("d3 unknown no vld", 256'(rd_vld3), 256'(0));
        chk("d3 drop after unknown", 256'(drop3), 256'(0));
        ack3 = {2'd0, 64'h44};
        ack_wr3 = 1'b1;
        tick();
        ack_wr3 = 1'b0;
        tick();
        chk("d3 ch0 vld", 256'(rd_vld3), 256'(3'b001));
        chk("d3 ch0 dat", 256'(rd_dat3), 256'(64'h44));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ack_type_dispatch.md
Name: ack_type_dispatch

Overview:
- Multi-channel successor to the single-type command-ack filter in the TSMP agent network-management path.
- Classifies each incoming typed command ack by its type field and steers it to one of CH_NUM per-type channels.
- Each channel has its own DEPTH-entry FIFO and a valid/ready output, so slow consumers (read-ack packer, write-ack logger, ...) do not lose acks.
- Counts acks dropped on full or disabled channels and acks with an unsupported type.

Parameters:
- DATA_W, 64: ack payload width.
- TYPE_W, 2: type field width; the type field occupies the MSBs of the input word.
- CH_NUM, 4: number of channels; 1 <= CH_NUM <= 2^TYPE_W; channel k serves type code k.
- DEPTH, 4: FIFO entries per channel; power of 2, >= 2.
- CNT_W, 16: width of each drop counter.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous, active-high reset.
- iv_command_ack  in  TYPE_W+DATA_W  [TYPE_W+DATA_W-1:DATA_W] = type, [DATA_W-1:0] = payload.
- i_command_ack_wr  in  1  input word valid. No back-pressure; one word accepted per cycle.
- iv_ch_enable  in  CH_NUM  per-channel enable. A disabled channel drops its acks.
- i_cnt_clr  in  1  synchronous clear of all counters.
- ov_rd_command_ack  out  CH_NUM*DATA_W  channel k head payload at [k*DATA_W +: DATA_W].
- o_rd_command_ack_wr  out  CH_NUM  channel k head valid.
- i_rd_command_ack_rdy  in  CH_NUM  channel k consumer ready.
- ov_drop_cnt  out  CH_NUM*CNT_W  channel k drop count at [k*CNT_W +: CNT_W].
- ov_unknown_cnt  out  CNT_W  count of acks with type >= CH_NUM.

Behaviour:
- Reset (i_rst=1 at a clock edge):
  - All FIFOs flush: pointers and occupancy go to 0.
  - All outputs go to 0 on the next edge: ov_rd_command_ack, o_rd_command_ack_wr, ov_drop_cnt, ov_unknown_cnt.
  - Reset mid-transfer discards all stored acks. The input word present in the reset cycle is ignored.
- Classification, in a cycle with i_command_ack_wr=1 and t = type field:
  - t >= CH_NUM: ov_unknown_cnt += 1; no channel is written.
  - t < CH_NUM and iv_ch_enable[t]=0: ov_drop_cnt[t] += 1.
  - t < CH_NUM, enabled, and FIFO t not full, or full with a pop in the same cycle: payload is pushed.
  - Otherwise (FIFO t full, no pop): ov_drop_cnt[t] += 1; FIFO contents are unchanged.
- Per-channel FIFO:
  - Show-ahead. The head is presented on ov_rd_command_ack[k] with o_rd_command_ack_wr[k]=1 while the FIFO is non-empty.
  - Pop occurs when o_rd_command_ack_wr[k] & i_rd_command_ack_rdy[k].
  - Latency: a word written at edge N is visible at the output after edge N+1, i.e. one registered stage, the same as the predecessor block.
  - When a channel is empty its payload output is 0, and valid stays low.
  - Simultaneous push and pop on a non-empty FIFO: occupancy is unchanged and order is preserved.
  - Push and pop on an empty FIFO cannot coincide, because valid is low.
  - Pointers are log2(DEPTH) bits and wrap naturally. Occupancy is log2(DEPTH)+1 bits, so full is occupancy == DEPTH.
- Enable changes:
  - Clearing iv_ch_enable[k] blocks new writes only.
  - Entries already queued remain readable.
- Counters:
  - Saturate at all-ones.
  - i_cnt_clr=1 forces all counters to 0 on the next edge. This takes priority over an increment in the same cycle; that event is not counted.
- Channels are fully independent. Back-pressure on one channel never affects another.

Test Plan:
- Send type=2'b11, payload 64'h0123_4567_89AB_CDEF with all ready=1 -> one cycle later o_rd_command_ack_wr=4'b1000 for exactly one cycle, ch3 payload = 0123_4567_89AB_CDEF, other channels show 0.
- Hold ch1 ready=0 and write 6 type-1 acks (payloads 1..6), DEPTH=4 -> entries 1..4 queued, ov_drop_cnt[1]=2. Then ready=1 -> payloads 1,2,3,4 come out on consecutive cycles, then valid drops.
- ch0 full with ready=1, then write type-0 payload 5 -> push accepted alongside the pop, ov_drop_cnt[0]=0, order preserved.
- Disable ch2 and write 3 type-2 acks -> no valid on ch2, ov_drop_cnt[2]=3. With CH_NUM=3, a type-3 write -> ov_unknown_cnt=1.
- Preload ov_drop_cnt[1]=16'hFFFE, then 3 drops -> counter stays at 16'hFFFF. Assert i_cnt_clr together with another drop -> counter reads 0.
- Queue 3 acks on ch0, assert i_rst for one cycle with a write present -> all valids 0, counters 0, and no acks emerge afterwards.
